seg_led_mux: RTL and testbench

SEG_LED_MUX -- requirements
Module: seg_led_mux

---
 rtl/seg_led_mux.sv | 247 ++++++++++++++++++++++++
 tb/tb_seg_led_mux.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_led_mux.sv
// seg_led_mux: APB-programmed, multiplexed 7-segment LED driver with PWM dimming.
// Optional blink support is compiled in when SEG_BLINK_EN is defined.
module seg_led_mux #(
    parameter int DIGITS       = 6,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int SCAN_FREQ    = 1000,
    parameter int DEAD_CYCLES  = 64,
    parameter int BLINK_FRAMES = 250
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [3:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic [DIGITS-1:0] seg_sel_n,
    output logic [7:0]        seg_data
);

    localparam int SLOT = CLK_FREQ / (SCAN_FREQ * DIGITS);
    localparam int UNIT = (SLOT - DEAD_CYCLES) >> 4;
    localparam int CW   = $clog2(SLOT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        ON
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] slot_cnt, slot_cnt_nx;
    logic [2:0]    idx, idx_nx;
    logic [3:0]    bright_lat;
    logic          frame_tick;

    logic [7:0]    dig [8];
    logic [1:0]    ctrl;
    logic [3:0]    bright;
    logic [7:0]    blink;
    logic          blink_phase;

    logic          wr, rd, scan_en, lit, blanked;
    logic [31:0]   rdata, lit_end;
    logic [7:0]    cur, hex, pat;
    logic          unused_bits;

    assign wr = psel & penable & pwrite;
    assign rd = psel & penable & ~pwrite;

    // A CTRL write in flight wins over the stored enable so the FSM obeys it at once.
    assign scan_en = (wr && paddr == 4'h8) ? pwdata[0] : ctrl[0];

    assign unused_bits = ^pwdata[31:8];

    // Register file writes; out-of-range digits and read-only locations are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                dig[i] <= 8'h00;
            end
            ctrl   <= 2'b01;
            bright <= 4'hF;
        end else if (wr) begin
            if (!paddr[3] && {29'b0, paddr[2:0]} < 32'(DIGITS)) begin
                dig[paddr[2:0]] <= pwdata[7:0];
            end
            if (paddr == 4'h8) begin
                ctrl <= pwdata[1:0];
            end
            if (paddr == 4'h9) begin
                bright <= pwdata[3:0];
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    logic [BW-1:0] frame_cnt;

    // Blink mask register and the frame divider that flips the blink phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink       <= 8'h00;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (wr && paddr == 4'hA) begin
                blink <= 8'(pwdata[DIGITS-1:0]);
            end
            if (frame_tick) begin
                if (frame_cnt == BW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_tick;
    assign unused_tick = frame_tick;
    assign blink       = 8'h00;
    assign blink_phase = 1'b0;
`endif

    // Scan state register; brightness is captured on every entry to DEAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot_cnt   <= '0;
            idx        <= 3'd0;
            bright_lat <= 4'hF;
        end else begin
            state    <= state_nx;
            slot_cnt <= slot_cnt_nx;
            idx      <= idx_nx;
            if (state_nx == DEAD && state != DEAD) begin
                bright_lat <= bright;
            end
        end
    end

    // Slot sequencing: DEAD gap, then ON, then advance to the next digit.
    always_comb begin
        state_nx    = state;
        slot_cnt_nx = slot_cnt + 1'b1;
        idx_nx      = idx;
        frame_tick  = 1'b0;
        unique case (state)
            IDLE: begin
                slot_cnt_nx = '0;
                idx_nx      = 3'd0;
                state_nx    = DEAD;
            end
            DEAD: begin
                if (slot_cnt == CW'(DEAD_CYCLES - 1)) begin
                    state_nx = ON;
                end
            end
            ON: begin
                if (slot_cnt == CW'(SLOT - 1)) begin
                    state_nx    = DEAD;
                    slot_cnt_nx = '0;
                    if (idx == 3'(DIGITS - 1)) begin
                        idx_nx     = 3'd0;
                        frame_tick = 1'b1;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (!scan_en) begin
            state_nx    = IDLE;
            slot_cnt_nx = '0;
            idx_nx      = 3'd0;
            frame_tick  = 1'b0;
        end
    end

    assign cur     = dig[idx];
    assign blanked = blink_phase & blink[idx];
    assign lit_end = 32'(DEAD_CYCLES)
                   + ({28'b0, bright_lat} + 32'd1) * 32'(UNIT);
    assign lit     = (state == ON) && (32'(slot_cnt) < lit_end);

    // Hex digit to active-low segment code {dp,g..a}.
    always_comb begin
        hex = 8'hFF;
        unique case (cur[3:0])
            4'h0: hex = 8'hC0;
            4'h1: hex = 8'hF9;
            4'h2: hex = 8'hA4;
            4'h3: hex = 8'hB0;
            4'h4: hex = 8'h99;
            4'h5: hex = 8'h92;
            4'h6: hex = 8'h82;
            4'h7: hex = 8'hF8;
            4'h8: hex = 8'h80;
            4'h9: hex = 8'h90;
            4'hA: hex = 8'h88;
            4'hB: hex = 8'h83;
            4'hC: hex = 8'hC6;
            4'hD: hex = 8'hA1;
            4'hE: hex = 8'h86;
            4'hF: hex = 8'h8E;
        endcase
    end

    // Segment pattern for the current digit: blink, raw, blank, then decode.
    always_comb begin
        pat = 8'hFF;
        if (blanked) begin
            pat = 8'hFF;
        end else if (ctrl[1]) begin
            pat = ~cur;
        end else if (cur[4]) begin
            pat = 8'hFF;
        end else begin
            pat = {~cur[7], hex[6:0]};
        end
    end

    // Registered drive of the display; everything dark outside the lit window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_sel_n <= '1;
            seg_data  <= 8'hFF;
        end else if (lit) begin
            seg_sel_n <= ~(DIGITS'(1) << idx);
            seg_data  <= pat;
        end else begin
            seg_sel_n <= '1;
            seg_data  <= 8'hFF;
        end
    end

    // Read mux, zero-extended; unmapped locations return zero.
    always_comb begin
        rdata = 32'h0;
        case (paddr)
            4'h8: rdata = {30'b0, ctrl};
            4'h9: rdata = {28'b0, bright};
            4'hA: rdata = {24'b0, blink};
            4'hB: rdata = {23'b0, blink_phase, 5'b0, idx};
            default: begin
                if (!paddr[3] && {29'b0, paddr[2:0]} < 32'(DIGITS)) begin
                    rdata = {24'b0, dig[paddr[2:0]]};
                end
            end
        endcase
    end

    // Read data register, loaded in the APB access cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prdata <= 32'h0;
        end else if (rd) begin
            prdata <= rdata;
        end
    end

endmodule

// File: tb/tb_seg_led_mux.sv
// tb_seg_led_mux: randomized APB traffic against a slot-timeline reference model.
// A scoreboard queue carries the expected display and prdata for every clock.
module tb_seg_led_mux;

    localparam int DIGITS       = 4;
    localparam int CLK_FREQ     = 128000;
    localparam int SCAN_FREQ    = 1000;
    localparam int DEAD_CYCLES  = 16;
    localparam int BLINK_FRAMES = 2;
    localparam int SLOT         = CLK_FREQ / (SCAN_FREQ * DIGITS);
    localparam int UNIT         = (SLOT - DEAD_CYCLES) / 16;
    localparam int FRAME        = SLOT * DIGITS;
`ifdef SEG_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              psel, penable, pwrite;
    logic [3:0]        paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic [DIGITS-1:0] seg_sel_n;
    logic [7:0]        seg_data;

    seg_led_mux #(
        .DIGITS       (DIGITS),
        .CLK_FREQ     (CLK_FREQ),
        .SCAN_FREQ    (SCAN_FREQ),
        .DEAD_CYCLES  (DEAD_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .seg_sel_n (seg_sel_n),
        .seg_data  (seg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DIGITS-1:0] sel;
        logic [7:0]        data;
        logic [31:0]       prd;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
                                  8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83,
                                  8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0]  m_dig [DIGITS];
    logic [1:0]  m_ctrl;
    logic [3:0]  m_bright;
    logic [3:0]  m_blink;
    logic [31:0] m_prdata;
    logic [3:0]  slot_br;
    bit          running;
    int          k;
    int          frames;

    function automatic logic [7:0] pattern(logic [7:0] v, bit raw, bit hide);
        logic [7:0] r;
        if (hide) return 8'hFF;
        if (raw) return ~v;
        if (v[4]) return 8'hFF;
        r = hex_tab[v[3:0]];
        if (v[7]) r[7] = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] rd_model(logic [3:0] a, bit ph, int ix);
        logic [2:0] i3;
        i3 = 3'(ix);
        if (a < DIGITS) return {24'b0, m_dig[a[1:0]]};
        case (a)
            4'h8:    return {30'b0, m_ctrl};
            4'h9:    return {28'b0, m_bright};
            4'hA:    return {28'b0, m_blink};
            4'hB:    return {23'b0, ph, 5'b0, i3};
            default: return 32'h0;
        endcase
    endfunction

    // Reference model: display is a function of cycles elapsed since scanning began.
    always @(posedge clk) begin : model
        exp_t e;
        bit   wr_c, rd_c, en, ph;
        int   ix, pos;
        wr_c   = psel && penable && pwrite;
        rd_c   = psel && penable && !pwrite;
        e.sel  = '1;
        e.data = 8'hFF;
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) m_dig[i] = 8'h00;
            m_ctrl   = 2'b01;
            m_bright = 4'hF;
            m_blink  = 4'h0;
            m_prdata = 32'h0;
            slot_br  = 4'hF;
            running  = 1'b0;
            k        = 0;
            frames   = 0;
        end else begin
            ph  = BLINK_ON && ((frames / BLINK_FRAMES) % 2 == 1);
            ix  = running ? (k / SLOT) % DIGITS : 0;
            pos = k % SLOT;
            if (running && pos >= DEAD_CYCLES &&
                pos - DEAD_CYCLES < (int'(slot_br) + 1) * UNIT) begin
                e.sel  = ~(DIGITS'(1) << ix);
                e.data = pattern(m_dig[ix], m_ctrl[1], ph && m_blink[ix]);
            end
            if (rd_c) m_prdata = rd_model(paddr, ph, ix);
            en = (wr_c && paddr == 4'h8) ? pwdata[0] : m_ctrl[0];
            if (!en) begin
                running = 1'b0;
                k       = 0;
            end else begin
                if (running) k++;
                else begin
                    running = 1'b1;
                    k       = 0;
                end
                if (k % SLOT == 0) slot_br = m_bright;
                if (k > 0 && k % FRAME == 0) frames++;
            end
            if (wr_c) begin
                if (paddr < DIGITS) m_dig[paddr[1:0]] = pwdata[7:0];
                if (paddr == 4'h8) m_ctrl = pwdata[1:0];
                if (paddr == 4'h9) m_bright = pwdata[3:0];
                if (paddr == 4'hA && BLINK_ON) m_blink = pwdata[3:0];
            end
        end
        e.prd = m_prdata;
        exp_q.push_back(e);
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Monitor: one expected record per clock, compared away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seg_sel_n", 32'(seg_sel_n), 32'(e.sel));
            check("seg_data", 32'(seg_data), 32'(e.data));
            check("prdata", prdata, e.prd);
        end
    end

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_k(input int modulus, input int val);
        for (int n = 0; n < 4000; n++) begin
            if (running && k % modulus == val) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_k: got timeout expected scan position %0d", val);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  a;
        logic [31:0] d;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 4'h0; pwdata = 32'h0;
        idle(3);
        rst_n = 1'b1;
        idle(200);
        apb_write(4'h0, 32'h85);
        apb_write(4'h1, 32'h13);
        apb_write(4'h2, $urandom);
        apb_write(4'h3, $urandom);
        idle(300);
        wait_k(SLOT, 20);
        apb_write(4'h9, 32'h3);
        idle(200);
        apb_write(4'h8, 32'h3);
        apb_write(4'h2, 32'h5A);
        idle(150);
        apb_write(4'h8, 32'h0);
        idle(2);
        apb_read(4'hB);
        idle(5);
        apb_write(4'h9, 32'hF);
        apb_write(4'h8, 32'h1);
        apb_write(4'h0, 32'h08);
        apb_write(4'hA, 32'h1);
        apb_read(4'hA);
        for (int i = 0; i < 24; i++) begin
            idle(45);
            apb_read(4'hB);
        end
        apb_read(4'h7);
        apb_read(4'hC);
        apb_read(4'hF);
        for (int i = 0; i < 16; i++) apb_read(4'(i));
        wait_k(FRAME, FRAME - 2);
        apb_write(4'h8, 32'h0);
        idle(10);
        apb_write(4'h8, 32'h1);
        wait_k(FRAME, FRAME - 2);
        apb_write(4'h8, 32'h3);
        idle(20);
        for (int i = 0; i < 300; i++) begin
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            if (a == 4'h8) d[0] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) apb_write(a, d);
            else apb_read(a);
            idle($urandom_range(0, 20));
        end
        apb_write(4'h8, 32'h1);
        apb_write(4'h9, 32'hF);
        wait_k(SLOT, 20);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(150);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
